spi_arbiter: RTL and testbench
==============================

// Module: spi_arbiter
// PURPOSE
// Shares the single SPI engine (flash/TF shifter, TX/RX buffers) between two requesters:
// requester 0 (host register path) and requester 1 (autonomous boot/ROM loader).
// Grants ownership, latches the transfer config, pulses the engine start and drives /CS.
// Lets an owner keep /CS low across several back-to-back transfers without losing the bus.
// PARAMETERS
// BUSY_WAIT  4     max FastClk cycles from SPI_Start to SPI_Busy rising before the transfer errors
// HOLD_MAX   4096  max cycles an owner may idle in HOLD while the other requester waits; 0 = unlimited
// PORTS
// FastClk     in   1  block clock, same as the SPI engine FastClk
// nReset      in   1  asynchronous active-low reset
// Req[1:0]    in   2  per-requester transfer request, level; held until Done or Err
// Len0/Len1   in   9  byte count minus 1 (0..511) for requester 0/1
// Mode0/Mode1 in   2  engine mode: 0 write, 1 read, 2 exchange, 3 wait-and-read
// Slow0/Slow1 in   1  select slow SPI clock
// Dev0/Dev1   in   1  device select: 0 SPI flash, 1 TF card
// HoldCs[1:0] in   2  per requester: keep /CS low and ownership after this transfer
// Gnt[1:0]    out  2  one-hot ownership; at most one bit set
// Done[1:0]   out  2  one-cycle pulse, transfer completed
// Err[1:0]    out  2  one-cycle pulse, transfer aborted (busy timeout or forced release)
// SPI_Start   out  1  one-cycle start pulse to the engine
// SPI_Len     out  9  latched length
// SPI_Mode    out  2  latched mode
// SPI_Slow    out  1  latched clock select
// SPI_Dev     out  1  latched device select
// SPI_CsLo    out  1  /CS assert request to the engine (1 = /CS low on SPI_Dev)
// SPI_Busy    in   1  engine busy (SPICnt bit 15)
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, round-robin pointer = 0 (requester 0 wins the first tie).
// States: IDLE, START, RUN, HOLD. Transitions are registered; all outputs are registered.
// IDLE: if any Req is set, pick the winner -> START. Ties go to the requester not served last.
// START (1 cycle): Gnt[w]=1, SPI_Start=1, SPI_Len/Mode/Slow/Dev latched from the winner, SPI_CsLo=1 -> RUN.
//   Latency: Req sampled on cycle N -> SPI_Start is high on cycle N+1.
// RUN: wait for SPI_Busy to rise, then for it to fall. The cycle after the fall: Done[w]=1.
//   With HoldCs[w]=1 (sampled at the fall) -> HOLD, Gnt and CsLo stay set.
//   With HoldCs[w]=0 -> IDLE, Gnt=0, CsLo=0, pointer = w.
//   If SPI_Busy has not risen within BUSY_WAIT cycles of SPI_Start: Err[w]=1 (no Done), release as above.
// HOLD: Gnt[w]=1, SPI_CsLo=1.
//   Owner Req=1 -> START for the owner with the new config. The other requester is not considered.
//   Owner HoldCs=0 and Req=0 -> IDLE, CsLo=0, Gnt=0, pointer = w.
//   With HOLD_MAX!=0, the other Req pending and HOLD_MAX idle cycles elapsed: Err[w]=1, forced release -> IDLE.
// Config is latched only in START. Input changes during RUN do not affect the running transfer.
// Requester dropping Req during RUN: the transfer still completes and Done is still pulsed.
// Requesters must hold Req until Done/Err. Req still high after Done in IDLE counts as a new request.
// Done and Err are never both set, and only the owner's bit may pulse.
// Release and regrant never overlap: /CS is deasserted for at least 1 cycle (the IDLE cycle) between owners.
// Reset mid-operation: outputs return to 0 immediately (SPI_CsLo=0 releases /CS). No Done/Err is issued.
// Counters: busy-wait counter is 3+ bits wide (sized to BUSY_WAIT).
//   Hold counter is 13 bits wide (sized to HOLD_MAX) and saturates.
//   Both counters clear on every state entry.
// TESTING
// 1 Req0, Len0=3, Mode0=2, Slow0=1; fake engine raises Busy 1 cycle after Start for 40 cycles
//   -> SPI_Start 1 cycle after Req; SPI_Len=3, Mode=2; Done[0] once; Gnt/CsLo low after.
// 2 Req0 and Req1 in the same cycle, twice in succession
//   -> first grant goes to 0, second to 1; Gnt is never 2'b11; /CS is high for >=1 cycle between grants.
// 3 Req1 with HoldCs1=1 (Len=0, Mode=3), then Req0 pending, then a second Req1 with HoldCs1=0
//   -> both Req1 transfers run before Gnt[0]; CsLo stays high across them.
// 4 Engine never raises Busy -> Err[0] exactly BUSY_WAIT cycles after Start; no Done; CsLo=0.
// 5 HOLD_MAX=16; owner 1 idles in HOLD while Req0 is pending
//   -> Err[1] after 16 cycles, then Req0 is granted.
// 6 nReset asserted mid-RUN -> all outputs 0 asynchronously. After release, Req0 is granted normally.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Shares the single SPI engine between two requesters: requester 0 (host
//   register path) and requester 1 (boot/ROM loader). Grants ownership,
//   latches the transfer config, pulses the engine start and drives /CS.
//   An owner may keep /CS low across back-to-back transfers (HoldCs).
//
// Ports
//   FastClk, nReset           block clock, async active-low reset
//   Req[1:0]                  per-requester transfer request (level)
//   Len0/1, Mode0/1,
//   Slow0/1, Dev0/1           per-requester transfer config
//   HoldCs[1:0]               keep /CS and ownership after the transfer
//   Gnt[1:0]                  one-hot ownership
//   Done[1:0], Err[1:0]       one-cycle completion / abort pulses
//   SPI_Start                 one-cycle engine start pulse
//   SPI_Len/Mode/Slow/Dev     config latched at start
//   SPI_CsLo                  /CS assert request to the engine
//   SPI_Busy                  engine busy flag
module spi_arbiter #(
  parameter int unsigned BUSY_WAIT = 4,
  parameter int unsigned HOLD_MAX  = 4096
) (
  input  logic       FastClk,
  input  logic       nReset,
  input  logic [1:0] Req,
  input  logic [8:0] Len0,
  input  logic [8:0] Len1,
  input  logic [1:0] Mode0,
  input  logic [1:0] Mode1,
  input  logic       Slow0,
  input  logic       Slow1,
  input  logic       Dev0,
  input  logic       Dev1,
  input  logic [1:0] HoldCs,
  output logic [1:0] Gnt,
  output logic [1:0] Done,
  output logic [1:0] Err,
  output logic       SPI_Start,
  output logic [8:0] SPI_Len,
  output logic [1:0] SPI_Mode,
  output logic       SPI_Slow,
  output logic       SPI_Dev,
  output logic       SPI_CsLo,
  input  logic       SPI_Busy
);

  localparam int unsigned BW_W = ($clog2(BUSY_WAIT + 1) < 3) ? 3 : $clog2(BUSY_WAIT + 1);
  localparam int unsigned HC_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    HOLD
  } state_t;

  state_t          state;
  logic            owner;      // index of the current owner
  logic            prio;       // requester favoured on the next tie (the one not served last)
  logic            busy_seen;  // SPI_Busy has risen during this transfer
  logic [BW_W-1:0] bw_cnt;
  logic [HC_W-1:0] hold_cnt;

  logic       win;
  logic       sel;
  logic [8:0] sel_len;
  logic [1:0] sel_mode;
  logic       sel_slow;
  logic       sel_dev;
  logic       own_req;
  logic       own_hold;
  logic       oth_req;
  logic       bw_expired;
  logic       hold_expired;

  always_comb begin
    win          = 1'b0;
    sel          = 1'b0;
    sel_len      = '0;
    sel_mode     = '0;
    sel_slow     = 1'b0;
    sel_dev      = 1'b0;
    own_req      = 1'b0;
    own_hold     = 1'b0;
    oth_req      = 1'b0;
    bw_expired   = 1'b0;
    hold_expired = 1'b0;

    if (Req == 2'b11) win = prio;
    else              win = Req[1];

    // In HOLD only the owner can start again; otherwise the arbitration winner.
    sel      = (state == HOLD) ? owner : win;
    sel_len  = sel ? Len1  : Len0;
    sel_mode = sel ? Mode1 : Mode0;
    sel_slow = sel ? Slow1 : Slow0;
    sel_dev  = sel ? Dev1  : Dev0;

    own_req  = Req[owner];
    own_hold = HoldCs[owner];
    oth_req  = Req[~owner];

    // bw_cnt is 0 in the first RUN cycle (one cycle after SPI_Start), so
    // the last chance for Busy to rise is the cycle where bw_cnt = BUSY_WAIT-2;
    // the registered Err then lands exactly BUSY_WAIT cycles after SPI_Start.
    bw_expired   = !busy_seen && !SPI_Busy && ((32'(bw_cnt) + 32'd2) >= BUSY_WAIT);
    // hold_cnt is 0 in the cycle Done pulses; Err lands HOLD_MAX cycles later.
    hold_expired = (HOLD_MAX != 0) && oth_req && ((32'(hold_cnt) + 32'd1) >= HOLD_MAX);
  end

  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      prio      <= 1'b0;
      busy_seen <= 1'b0;
      bw_cnt    <= '0;
      hold_cnt  <= '0;
      Gnt       <= '0;
      Done      <= '0;
      Err       <= '0;
      SPI_Start <= 1'b0;
      SPI_Len   <= '0;
      SPI_Mode  <= '0;
      SPI_Slow  <= 1'b0;
      SPI_Dev   <= 1'b0;
      SPI_CsLo  <= 1'b0;
    end else begin
      SPI_Start <= 1'b0;
      Done      <= '0;
      Err       <= '0;

      case (state)
        IDLE: begin
          if (|Req) begin
            state     <= START;
            owner     <= win;
            Gnt       <= win ? 2'b10 : 2'b01;
            SPI_Start <= 1'b1;
            SPI_CsLo  <= 1'b1;
            SPI_Len   <= sel_len;
            SPI_Mode  <= sel_mode;
            SPI_Slow  <= sel_slow;
            SPI_Dev   <= sel_dev;
            bw_cnt    <= '0;
            hold_cnt  <= '0;
          end
        end

        START: begin
          state     <= RUN;
          busy_seen <= 1'b0;
          bw_cnt    <= '0;
          hold_cnt  <= '0;
        end

        RUN: begin
          if (SPI_Busy) busy_seen <= 1'b1;
          if (bw_cnt != '1) bw_cnt <= bw_cnt + 1'b1;

          if (busy_seen && !SPI_Busy) begin
            Done[owner] <= 1'b1;
            bw_cnt      <= '0;
            hold_cnt    <= '0;
            if (own_hold) begin
              state <= HOLD;
            end else begin
              state    <= IDLE;
              Gnt      <= '0;
              SPI_CsLo <= 1'b0;
              prio     <= ~owner;
            end
          end else if (bw_expired) begin
            Err[owner] <= 1'b1;
            state      <= IDLE;
            Gnt        <= '0;
            SPI_CsLo   <= 1'b0;
            prio       <= ~owner;
            bw_cnt     <= '0;
            hold_cnt   <= '0;
          end
        end

        HOLD: begin
          if (own_req) begin
            state     <= START;
            SPI_Start <= 1'b1;
            SPI_Len   <= sel_len;
            SPI_Mode  <= sel_mode;
            SPI_Slow  <= sel_slow;
            SPI_Dev   <= sel_dev;
            bw_cnt    <= '0;
            hold_cnt  <= '0;
          end else if (!own_hold) begin
            state    <= IDLE;
            Gnt      <= '0;
            SPI_CsLo <= 1'b0;
            prio     <= ~owner;
            hold_cnt <= '0;
          end else if (hold_expired) begin
            Err[owner] <= 1'b1;
            state      <= IDLE;
            Gnt        <= '0;
            SPI_CsLo   <= 1'b0;
            prio       <= ~owner;
            hold_cnt   <= '0;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          Gnt      <= '0;
          SPI_CsLo <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter
//   Randomized self-checking bench for spi_arbiter. A behavioural engine
//   answers SPI_Start with a configurable Busy pulse; expected grant order,
//   start/end cycles and pulse counts are computed from the arbitration rules.
`timescale 1ns/1ps
module tb_spi_arbiter;

  localparam int BUSY_WAIT = 4;
  localparam int HOLD_MAX  = 16;

  logic       FastClk = 1'b0;
  logic       nReset  = 1'b0;
  logic [1:0] Req     = '0;
  logic [1:0] HoldCs  = '0;
  logic [8:0] tlen  [2];
  logic [1:0] tmode [2];
  logic       tslow [2];
  logic       tdev  [2];

  logic [8:0] Len0, Len1;
  logic [1:0] Mode0, Mode1;
  logic       Slow0, Slow1, Dev0, Dev1;
  logic [1:0] Gnt, Done, Err;
  logic       SPI_Start, SPI_Slow, SPI_Dev, SPI_CsLo;
  logic [8:0] SPI_Len;
  logic [1:0] SPI_Mode;
  logic       SPI_Busy;

  assign Len0  = tlen[0];
  assign Len1  = tlen[1];
  assign Mode0 = tmode[0];
  assign Mode1 = tmode[1];
  assign Slow0 = tslow[0];
  assign Slow1 = tslow[1];
  assign Dev0  = tdev[0];
  assign Dev1  = tdev[1];

  spi_arbiter #(.BUSY_WAIT(BUSY_WAIT), .HOLD_MAX(HOLD_MAX)) dut (
    .FastClk  (FastClk),
    .nReset   (nReset),
    .Req      (Req),
    .Len0     (Len0),
    .Len1     (Len1),
    .Mode0    (Mode0),
    .Mode1    (Mode1),
    .Slow0    (Slow0),
    .Slow1    (Slow1),
    .Dev0     (Dev0),
    .Dev1     (Dev1),
    .HoldCs   (HoldCs),
    .Gnt      (Gnt),
    .Done     (Done),
    .Err      (Err),
    .SPI_Start(SPI_Start),
    .SPI_Len  (SPI_Len),
    .SPI_Mode (SPI_Mode),
    .SPI_Slow (SPI_Slow),
    .SPI_Dev  (SPI_Dev),
    .SPI_CsLo (SPI_CsLo),
    .SPI_Busy (SPI_Busy)
  );

  always #5 FastClk = ~FastClk;

  int cyc = 0;
  always @(posedge FastClk) cyc <= cyc + 1;

  // Behavioural engine: Busy rises eng_delay cycles after the Start cycle
  // and stays high for eng_len cycles; a dead engine never answers.
  bit eng_dead  = 1'b0;
  int eng_delay = 1;
  int eng_len   = 1;
  int e_wait    = 0;
  int e_run     = 0;

  always @(posedge FastClk or negedge nReset) begin
    if (!nReset) begin
      SPI_Busy <= 1'b0;
      e_wait   <= 0;
      e_run    <= 0;
    end else if (SPI_Start && !eng_dead) begin
      if (eng_delay <= 1) begin
        SPI_Busy <= 1'b1;
        e_run    <= eng_len - 1;
        e_wait   <= 0;
      end else begin
        e_wait <= eng_delay - 1;
      end
    end else if (e_wait != 0) begin
      e_wait <= e_wait - 1;
      if (e_wait == 1) begin
        SPI_Busy <= 1'b1;
        e_run    <= eng_len - 1;
      end
    end else if (SPI_Busy) begin
      if (e_run == 0) SPI_Busy <= 1'b0;
      else            e_run    <= e_run - 1;
    end
  end

  // Protocol monitors and pulse counters.
  logic [1:0] prev_gnt = '0;
  int v_both = 0, v_overlap = 0, v_owner = 0, v_cs = 0, v_swap = 0;
  int act_done [2] = '{0, 0};
  int act_err  [2] = '{0, 0};
  int exp_done [2] = '{0, 0};
  int exp_err  [2] = '{0, 0};

  always @(negedge FastClk) begin
    if (Gnt == 2'b11) v_both++;
    if ((Done & Err) != 2'b00) v_overlap++;
    if (((Done | Err) & ~prev_gnt) != 2'b00) v_owner++;
    if (SPI_CsLo != (|Gnt)) v_cs++;
    if (prev_gnt != 2'b00 && Gnt != 2'b00 && Gnt != prev_gnt) v_swap++;
    for (int b = 0; b < 2; b++) begin
      if (Done[b]) act_done[b]++;
      if (Err[b])  act_err[b]++;
    end
    prev_gnt = Gnt;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: arbitration winner from the requests and history.
  int last_served = -1;

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return (last_served == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  function automatic logic [12:0] cfg_of(input int r);
    return {tlen[r], tmode[r], tslow[r], tdev[r]};
  endfunction

  function automatic logic [20:0] all_outs();
    return {Gnt, Done, Err, SPI_Start, SPI_Len, SPI_Mode, SPI_Slow, SPI_Dev, SPI_CsLo};
  endfunction

  task automatic rand_cfg(input int r);
    tlen[r]  = 9'($urandom_range(0, 511));
    tmode[r] = 2'($urandom_range(0, 3));
    tslow[r] = 1'($urandom_range(0, 1));
    tdev[r]  = 1'($urandom_range(0, 1));
  endtask

  bit pend_other = 1'b0;  // raise the other requester's Req at this transfer's start

  // Follows one transfer of requester w through to Done/Err.
  task automatic do_xfer(input int w, input int exp_ts, input bit dead, input int d,
                         input int blen, input bit hold_after, input bit drop_early,
                         output int t_end);
    int          ts;
    logic [1:0]  g;
    logic [12:0] snap;
    eng_dead  = dead;
    eng_delay = d;
    eng_len   = blen;
    HoldCs[w] = hold_after;
    g         = (w == 1) ? 2'b10 : 2'b01;
    ts        = -1;
    t_end     = -1;
    snap      = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge FastClk);
      if (SPI_Start && ts < 0) begin
        ts = cyc;
        check("start_time", ts, exp_ts);
        check("start_gnt", {30'd0, Gnt}, {30'd0, g});
        snap = cfg_of(w);
        check("start_cfg", {SPI_Len, SPI_Mode, SPI_Slow, SPI_Dev, SPI_CsLo}, {snap, 1'b1});
        rand_cfg(w);
        if (drop_early) Req[w] = 1'b0;
        if (pend_other) Req[1 - w] = 1'b1;
      end else if (ts >= 0 && (Done != 2'b00 || Err != 2'b00)) begin
        t_end = cyc;
        if (dead) begin
          check("err_time", t_end, ts + BUSY_WAIT);
          check("err_bits", {Done, Err}, {2'b00, g});
          exp_err[w]++;
          check("err_release", {Gnt, SPI_CsLo}, 3'b000);
        end else begin
          check("done_time", t_end, ts + d + blen + 1);
          check("done_bits", {Done, Err}, {g, 2'b00});
          exp_done[w]++;
          check("done_gnt", {Gnt, SPI_CsLo}, hold_after ? {g, 1'b1} : 3'b000);
        end
        check("cfg_held", {SPI_Len, SPI_Mode, SPI_Slow, SPI_Dev}, snap);
        Req[w] = 1'b0;
        break;
      end
    end
    check("xfer_end_seen", (t_end >= 0), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int  c, w, e1, e2, te, pat, dd, bl;
  bit  r0, r1, dead;

  initial begin
    for (int r = 0; r < 2; r++) begin
      tlen[r] = '0; tmode[r] = '0; tslow[r] = 1'b0; tdev[r] = 1'b0;
    end
    repeat (3) @(negedge FastClk);
    check("reset_outputs", {11'd0, all_outs()}, 32'd0);
    nReset = 1'b1;
    @(negedge FastClk);

    // Simultaneous requests twice: 0 then 1 each time, /CS gap between.
    for (int k = 0; k < 2; k++) begin
      rand_cfg(0); rand_cfg(1);
      @(negedge FastClk);
      c = cyc; Req = 2'b11;
      w = pick(1'b1, 1'b1);
      do_xfer(w, c + 1, 1'b0, $urandom_range(1, 3), $urandom_range(2, 6), 1'b0, 1'b0, e1);
      last_served = w;
      do_xfer(1 - w, e1 + 1, 1'b0, $urandom_range(1, 3), $urandom_range(2, 6), 1'b0, 1'b0, e2);
      last_served = 1 - w;
      @(negedge FastClk);
    end

    // Single host transfer, long busy.
    rand_cfg(0);
    tlen[0] = 9'd3; tmode[0] = 2'd2; tslow[0] = 1'b1;
    @(negedge FastClk);
    c = cyc; Req = 2'b01;
    do_xfer(0, c + 1, 1'b0, 1, 40, 1'b0, 1'b0, e1);
    last_served = 0;

    // Engine never answers.
    rand_cfg(0);
    @(negedge FastClk);
    c = cyc; Req[0] = 1'b1;
    do_xfer(0, c + 1, 1'b1, 1, 1, 1'b0, 1'b0, e1);
    last_served = 0;
    repeat (3) @(negedge FastClk);

    // Loader keeps /CS across two transfers while host waits.
    rand_cfg(0); rand_cfg(1);
    tlen[1] = 9'd0; tmode[1] = 2'd3;
    @(negedge FastClk);
    c = cyc; Req[1] = 1'b1; pend_other = 1'b1;
    do_xfer(1, c + 1, 1'b0, 2, 3, 1'b1, 1'b0, e1);
    pend_other = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge FastClk);
      check("hold_state", {Gnt, SPI_CsLo, SPI_Start, Done, Err}, {2'b10, 1'b1, 1'b0, 4'b0000});
    end
    c = cyc; rand_cfg(1); Req[1] = 1'b1;
    do_xfer(1, c + 1, 1'b0, 1, 4, 1'b0, 1'b0, e2);
    do_xfer(0, e2 + 1, 1'b0, 3, 2, 1'b0, 1'b0, e1);
    last_served = 0;

    // Owner leaves HOLD by dropping HoldCs.
    rand_cfg(0);
    @(negedge FastClk);
    c = cyc; Req[0] = 1'b1;
    do_xfer(0, c + 1, 1'b0, 2, 3, 1'b1, 1'b0, e1);
    repeat (2) begin
      @(negedge FastClk);
      check("hold0_state", {Gnt, SPI_CsLo}, 3'b011);
    end
    HoldCs[0] = 1'b0;
    @(negedge FastClk);
    check("hold_exit", {Gnt, SPI_CsLo, Done, Err}, 7'd0);
    last_served = 0;

    // Idle HOLD owner is forced off after HOLD_MAX cycles.
    rand_cfg(0); rand_cfg(1);
    @(negedge FastClk);
    c = cyc; Req[1] = 1'b1; pend_other = 1'b1;
    do_xfer(1, c + 1, 1'b0, 1, 4, 1'b1, 1'b0, e1);
    pend_other = 1'b0;
    te = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge FastClk);
      if (Err != 2'b00 || Done != 2'b00 || Gnt != 2'b10) begin
        te = cyc;
        check("hold_to_bits", {Done, Err}, 4'b0010);
        break;
      end
    end
    check("hold_to_time", te, e1 + HOLD_MAX);
    exp_err[1]++;
    HoldCs[1] = 1'b0;
    last_served = 1;
    do_xfer(0, te + 1, 1'b0, 1, 3, 1'b0, 1'b0, e2);
    last_served = 0;

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      pat = $urandom_range(0, 2);
      r0  = (pat != 1);
      r1  = (pat != 0);
      rand_cfg(0); rand_cfg(1);
      @(negedge FastClk);
      c = cyc; Req = {r1, r0};
      w = pick(r0, r1);
      dead = ($urandom_range(0, 5) == 0);
      dd = $urandom_range(1, BUSY_WAIT - 1);
      bl = $urandom_range(1, 12);
      do_xfer(w, c + 1, dead, dd, bl, 1'b0, ($urandom_range(0, 3) == 0), e1);
      last_served = w;
      if (r0 && r1) begin
        dead = ($urandom_range(0, 5) == 0);
        dd = $urandom_range(1, BUSY_WAIT - 1);
        bl = $urandom_range(1, 12);
        do_xfer(1 - w, e1 + 1, dead, dd, bl, 1'b0, 1'b0, e2);
        last_served = 1 - w;
      end
      repeat ($urandom_range(0, 3)) @(negedge FastClk);
    end

    // Reset in the middle of a transfer.
    rand_cfg(0);
    @(negedge FastClk);
    Req[0] = 1'b1;
    eng_dead = 1'b0; eng_delay = 1; eng_len = 40;
    repeat (8) @(negedge FastClk);
    check("pre_reset_busy", {Gnt, SPI_CsLo}, 3'b011);
    #2 nReset = 1'b0;
    #1 check("reset_async", {11'd0, all_outs()}, 32'd0);
    @(negedge FastClk);
    check("reset_hold", {11'd0, all_outs()}, 32'd0);
    last_served = -1;
    c = cyc; nReset = 1'b1;
    do_xfer(0, c + 1, 1'b0, 2, 3, 1'b0, 1'b0, e1);
    repeat (3) @(negedge FastClk);

    check("done0_count", exp_done[0], act_done[0]);
    check("done1_count", exp_done[1], act_done[1]);
    check("err0_count",  exp_err[0],  act_err[0]);
    check("err1_count",  exp_err[1],  act_err[1]);
    check("gnt_both",    v_both,    0);
    check("done_err",    v_overlap, 0);
    check("pulse_owner", v_owner,   0);
    check("cs_vs_gnt",   v_cs,      0);
    check("gnt_swap",    v_swap,    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
